// File: rtl/sum_accumulator_pkg.sv
// Shared definitions for the adder-result block accumulator: state encoding,
// the adder data width and the default block geometry.
package sum_acc_pkg;

  localparam int DATA_W        = 8;
  localparam int DEFAULT_N     = 16;
  localparam int DEFAULT_ACC_W = 16;

  typedef enum logic {
    ST_ACCUM = 1'b0,
    ST_HOLD  = 1'b1
  } state_t;

endpackage

// File: rtl/sum_accumulator_if.sv
// Stream interface of sum_accumulator: 8-bit sample input with flush, and a
// block-result output (sum + sample count), both valid/ready.
interface sum_accumulator_if #(
  parameter int N     = sum_acc_pkg::DEFAULT_N,
  parameter int ACC_W = sum_acc_pkg::DEFAULT_ACC_W
);

  localparam int CNT_W = $clog2(N + 1);

  logic                          in_valid;
  logic                          in_ready;
  logic [sum_acc_pkg::DATA_W-1:0] in_data;
  logic                          flush;
  logic                          out_valid;
  logic                          out_ready;
  logic [ACC_W-1:0]              out_sum;
  logic [CNT_W-1:0]              out_count;

  modport master (
    output in_valid, in_data, flush, out_ready,
    input  in_ready, out_valid, out_sum, out_count
  );

  modport slave (
    input  in_valid, in_data, flush, out_ready,
    output in_ready, out_valid, out_sum, out_count
  );

endinterface

// File: rtl/sum_accumulator_acc_add.sv
// ACC_W + 8 -> ACC_W unsigned adder; wraps by default, saturates to all-ones
// when SUM_ACCUMULATOR_SAT_EN is defined.
module acc_add
  import sum_acc_pkg::*;
#(
  parameter int ACC_W = DEFAULT_ACC_W
) (
  input  logic [ACC_W-1:0]  a,
  input  logic [DATA_W-1:0] b,
  output logic [ACC_W-1:0]  sum
);

  logic [ACC_W:0] wide;

  assign wide = {1'b0, a} + {{(ACC_W + 1 - DATA_W){1'b0}}, b};

`ifdef SUM_ACCUMULATOR_SAT_EN
  // An all-ones accumulator plus any sample carries out, so saturation sticks.
  assign sum = wide[ACC_W] ? {ACC_W{1'b1}} : wide[ACC_W-1:0];
`else
  logic unused_carry;
  assign unused_carry = wide[ACC_W];
  assign sum          = wide[ACC_W-1:0];
`endif

endmodule

// File: rtl/sum_accumulator.sv
// Sums blocks of N adder results and hands out (sum, count) per block.
// Build option: SUM_ACCUMULATOR_SAT_EN selects saturating instead of wrapping sums.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int N     = DEFAULT_N,
  parameter int ACC_W = DEFAULT_ACC_W
) (
  input logic             clk,
  input logic             rst,
  sum_accumulator_if.slave bus
);

  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

  state_t           state_reg, state_next;
  logic [ACC_W-1:0] acc_reg, acc_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             out_valid_reg, out_valid_next;
  logic [ACC_W-1:0] out_sum_reg, out_sum_next;
  logic [CNT_W-1:0] out_count_reg, out_count_next;

  logic              accepting;
  logic              accept;
  logic              close;
  logic [DATA_W-1:0] add_b;
  logic [ACC_W-1:0]  add_sum;

  assign accepting = (state_reg == ST_ACCUM);
  assign accept    = bus.in_valid && accepting;
  // A flush only closes a block that will hold at least one sample.
  assign close     = accepting &&
                     ((accept && (cnt_reg == LAST_CNT)) ||
                      (bus.flush && ((cnt_reg != '0) || accept)));

  // The same adder feeds both the running sum and the closing block sum.
  assign add_b = accept ? bus.in_data : '0;

  acc_add #(
    .ACC_W (ACC_W)
  ) u_acc_add (
    .a   (acc_reg),
    .b   (add_b),
    .sum (add_sum)
  );

  always_comb begin
    state_next     = state_reg;
    acc_next       = acc_reg;
    cnt_next       = cnt_reg;
    out_valid_next = out_valid_reg;
    out_sum_next   = out_sum_reg;
    out_count_next = out_count_reg;

    case (state_reg)
      ST_ACCUM: begin
        if (accept) begin
          acc_next = add_sum;
          cnt_next = cnt_reg + CNT_W'(1);
        end
        if (close) begin
          out_sum_next   = add_sum;
          out_count_next = cnt_reg + (accept ? CNT_W'(1) : CNT_W'(0));
          out_valid_next = 1'b1;
          state_next     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (bus.out_ready) begin
          out_valid_next = 1'b0;
          acc_next       = '0;
          cnt_next       = '0;
          state_next     = ST_ACCUM;
        end
      end
      default: begin
        state_next = ST_ACCUM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= ST_ACCUM;
      acc_reg       <= '0;
      cnt_reg       <= '0;
      out_valid_reg <= 1'b0;
      out_sum_reg   <= '0;
      out_count_reg <= '0;
    end else begin
      state_reg     <= state_next;
      acc_reg       <= acc_next;
      cnt_reg       <= cnt_next;
      out_valid_reg <= out_valid_next;
      out_sum_reg   <= out_sum_next;
      out_count_reg <= out_count_next;
    end
  end

  assign bus.in_ready  = accepting;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sum   = out_sum_reg;
  assign bus.out_count = out_count_reg;

endmodule

// File: tb/tb_sum_accumulator.sv
// Self-checking bench: three accumulator geometries share one stimulus stream
// and are compared every cycle against a block-level sum model.
module tb_sum_accumulator;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic [7:0] in_data;
  logic       flush;
  logic       out_ready;

  int vectors;
  int miscompares;

  // instance geometry: 0 -> N=16/W=16, 1 -> N=4/W=16, 2 -> N=4/W=9
  int inst_n[3] = '{16, 4, 4};
  int inst_w[3] = '{16, 16, 9};

  // model: exact running total of the open block, and the last closed result
  bit     m_pending[3];
  longint m_total[3];
  int     m_n[3];
  longint m_sum[3];
  longint m_cnt[3];

  sum_accumulator_if #(.N(16), .ACC_W(16)) if16 ();
  sum_accumulator_if #(.N(4),  .ACC_W(16)) if4  ();
  sum_accumulator_if #(.N(4),  .ACC_W(9))  if9  ();

  assign if16.in_valid  = in_valid;
  assign if16.in_data   = in_data;
  assign if16.flush     = flush;
  assign if16.out_ready = out_ready;
  assign if4.in_valid   = in_valid;
  assign if4.in_data    = in_data;
  assign if4.flush      = flush;
  assign if4.out_ready  = out_ready;
  assign if9.in_valid   = in_valid;
  assign if9.in_data    = in_data;
  assign if9.flush      = flush;
  assign if9.out_ready  = out_ready;

  sum_accumulator #(.N(16), .ACC_W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(if16));
  sum_accumulator #(.N(4),  .ACC_W(16)) u_dut4  (.clk(clk), .rst(rst), .bus(if4));
  sum_accumulator #(.N(4),  .ACC_W(9))  u_dut9  (.clk(clk), .rst(rst), .bus(if9));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint fold(input longint total, input int w);
    longint lim;
    lim = longint'(1) << w;
`ifdef SUM_ACCUMULATOR_SAT_EN
    return (total >= lim) ? lim - 1 : total;
`else
    return total % lim;
`endif
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_step(input int i);
    if (rst) begin
      m_pending[i] = 0;
      m_total[i]   = 0;
      m_n[i]       = 0;
      m_sum[i]     = 0;
      m_cnt[i]     = 0;
    end else if (m_pending[i]) begin
      if (out_ready) begin
        m_pending[i] = 0;
        m_total[i]   = 0;
        m_n[i]       = 0;
      end
    end else begin
      if (in_valid) begin
        m_total[i] += longint'(in_data);
        m_n[i]++;
      end
      if (m_n[i] == inst_n[i] || (flush && m_n[i] > 0)) begin
        m_pending[i] = 1;
        m_sum[i]     = fold(m_total[i], inst_w[i]);
        m_cnt[i]     = m_n[i];
      end
    end
  endtask

  task automatic chk_inst(input int i, input logic v, input logic r,
                          input logic [63:0] s, input logic [63:0] c);
    chk($sformatf("inst%0d out_valid", i), {63'd0, v}, {63'd0, m_pending[i]});
    chk($sformatf("inst%0d in_ready", i),  {63'd0, r}, {63'd0, !m_pending[i]});
    chk($sformatf("inst%0d out_sum", i),   s, m_sum[i]);
    chk($sformatf("inst%0d out_count", i), c, m_cnt[i]);
  endtask

  // One clock: model consumes the inputs at the edge, outputs checked at negedge.
  task automatic tick();
    @(posedge clk);
    for (int i = 0; i < 3; i++) model_step(i);
    @(negedge clk);
    chk_inst(0, if16.out_valid, if16.in_ready, 64'(if16.out_sum), 64'(if16.out_count));
    chk_inst(1, if4.out_valid,  if4.in_ready,  64'(if4.out_sum),  64'(if4.out_count));
    chk_inst(2, if9.out_valid,  if9.in_ready,  64'(if9.out_sum),  64'(if9.out_count));
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  int     beats;
  int     not_ready;
  longint beat_sum;
  longint beat_cnt;

  initial begin
    vectors     = 0;
    miscompares = 0;
    for (int i = 0; i < 3; i++) begin
      m_pending[i] = 0; m_total[i] = 0; m_n[i] = 0; m_sum[i] = 0; m_cnt[i] = 0;
    end

    // reset held 3 cycles with valid data present: nothing may be counted
    rst = 1'b1; in_valid = 1'b1; in_data = 8'h55; flush = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    repeat (3) tick();
    chk("reset in_ready", 64'(if16.in_ready), 64'd1);
    chk("reset out_valid", 64'(if16.out_valid), 64'd0);
    chk("reset out_sum", 64'(if16.out_sum), 64'd0);
    rst = 1'b0; in_valid = 1'b0;
    tick();
    chk("reset no sample", 64'(if16.out_valid), 64'd0);

    // full block of 16 x 10 with continuous valid
    do_reset();
    in_data = 8'd10; beats = 0; not_ready = 0; beat_sum = -1; beat_cnt = -1;
    for (int k = 0; k < 20; k++) begin
      in_valid = (k < 16);
      tick();
      if (if16.out_valid) begin
        beats++;
        beat_sum = longint'(if16.out_sum);
        beat_cnt = longint'(if16.out_count);
      end
      if (!if16.in_ready) not_ready++;
    end
    chk("full beats", beats, 1);
    chk("full out_sum", beat_sum, 160);
    chk("full out_count", beat_cnt, 16);
    chk("full in_ready low cycles", not_ready, 1);

    // back-pressure on N=4: 1+2+3+4 held while out_ready stays low
    do_reset();
    out_ready = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      in_valid = 1'b1; in_data = 8'(k);
      tick();
    end
    in_data = 8'd9;
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp out_sum stable", 64'(if4.out_sum), 64'd10);
      chk("bp in_ready low", 64'(if4.in_ready), 64'd0);
    end
    out_ready = 1'b1; in_valid = 1'b0;
    tick();
    chk("bp released", 64'(if4.out_valid), 64'd0);

    // flush after 3 samples, then flush coincident with the 4th sample
    do_reset();
    in_data = 8'd7; in_valid = 1'b1;
    repeat (3) tick();
    in_valid = 1'b0; flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush3 out_valid", 64'(if16.out_valid), 64'd1);
    chk("flush3 out_sum", 64'(if16.out_sum), 64'd21);
    chk("flush3 out_count", 64'(if16.out_count), 64'd3);
    tick();
    in_valid = 1'b1;
    repeat (3) tick();
    in_data = 8'd5; flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush4 out_sum", 64'(if16.out_sum), 64'd26);
    chk("flush4 out_count", 64'(if16.out_count), 64'd4);
    tick();
    flush = 1'b1;
    tick();
    flush = 1'b0;
    chk("flush empty", 64'(if16.out_valid), 64'd0);
    tick();
    chk("flush empty later", 64'(if16.out_valid), 64'd0);

    // overflow: 4 x 255 into a 9-bit accumulator
    do_reset();
    in_data = 8'd255; in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    chk("ovf out_valid", 64'(if9.out_valid), 64'd1);
`ifdef SUM_ACCUMULATOR_SAT_EN
    chk("ovf out_sum", 64'(if9.out_sum), 64'd511);
`else
    chk("ovf out_sum", 64'(if9.out_sum), 64'd508);
`endif
    chk("ovf wide out_sum", 64'(if4.out_sum), 64'd1020);
    tick();

    // reset during HOLD discards the pending result
    do_reset();
    out_ready = 1'b0; in_data = 8'd3; in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    tick();
    chk("hold before rst", 64'(if4.out_valid), 64'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("hold rst out_valid", 64'(if4.out_valid), 64'd0);
    out_ready = 1'b1; in_data = 8'd1; in_valid = 1'b1;
    repeat (4) tick();
    in_valid = 1'b0;
    chk("post rst out_sum", 64'(if4.out_sum), 64'd4);
    chk("post rst out_valid", 64'(if4.out_valid), 64'd1);
    tick();

    // randomized traffic, half of it biased toward large samples
    for (int k = 0; k < 4000; k++) begin
      rst       = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = (k % 1000 < 500) ? 8'($urandom) : 8'($urandom_range(240, 255));
      flush     = ($urandom_range(0, 9) == 0);
      out_ready = ($urandom_range(0, 9) < 6);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sum_accumulator.md
Name: sum_accumulator

Overview:
- Downstream stage of the 8-bit combinational adder (res = a+b+1).
- Accepts a stream of 8-bit adder results over a valid/ready handshake.
- Sums a block of N results into a wider register, then presents the block sum and sample count on an output valid/ready handshake.
- A flush input closes a partial block early.

Parameters:
- N, 16, samples per block; legal range 2..255.
- ACC_W, 16, accumulator and out_sum width; legal range 9..32.
- CNT_W, $clog2(N+1), width of the internal counter and out_count (localparam, derived).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  in_data is valid.
- in_ready  output  1  block can accept a sample.
- in_data  input  8  adder result, unsigned.
- flush  input  1  single-cycle request to close the current block early.
- out_valid  output  1  out_sum and out_count are valid.
- out_ready  input  1  consumer accepts the result.
- out_sum  output  ACC_W  block sum.
- out_count  output  CNT_W  number of samples in the block.

Behaviour:
- All outputs are registered except in_ready, which decodes directly from state.
- Reset: on rst sampled high at a rising edge, registers take these values:
  - state = ACCUM;
  - acc = 0, cnt = 0;
  - out_valid = 0, out_sum = 0, out_count = 0.
  - in_ready reads 1 after reset.
  - Reset mid-block or mid-HOLD discards all data; no partial result is emitted.
- State ACCUM:
  - in_ready = 1, out_valid = 0.
  - Accept is in_valid && in_ready. On accept: acc <= acc + zero-extended in_data; cnt <= cnt + 1.
  - Close condition: an accept with cnt == N-1, OR (flush && (cnt > 0 || accept)).
  - On close:
    - out_sum <= acc + (accept ? in_data : 0);
    - out_count <= cnt + (accept ? 1 : 0);
    - out_valid <= 1; state <= HOLD.
  - Flush in the same cycle as an accept includes that sample.
  - Flush with cnt == 0 and no accept is ignored. No empty block is ever emitted.
  - Flush outside ACCUM is ignored.
- State HOLD:
  - in_ready = 0.
  - out_sum and out_count stay stable while out_valid && !out_ready.
  - On out_ready: out_valid <= 0; acc <= 0; cnt <= 0; state <= ACCUM.
- Latency:
  - Closing accept at edge t gives out_valid = 1 after edge t.
  - Minimum period is N+1 cycles per block, because HOLD lasts at least 1 cycle.
- Arithmetic:
  - Unsigned; in_data is zero-extended to ACC_W.
  - Without the optional feature, the sum wraps modulo 2^ACC_W.
- Back-pressure:
  - in_valid may be held high while in_ready = 0; nothing is accepted in HOLD.
  - Upstream must hold in_data stable until accepted.

Optional Feature:
- Macro: SUM_ACCUMULATOR_SAT_EN.
- Defined:
  - Accumulation saturates: if acc + in_data ≥ 2^ACC_W, acc holds all-ones (2^ACC_W − 1).
  - Once saturated, acc stays saturated until the block is cleared.
  - The closing out_sum applies the same rule.
- Undefined: modulo wrap, as described under Behaviour.
- Ports are identical in both builds.

Decomposition:
- Shared package/header sum_acc_pkg holds:
  - state encodings: ST_ACCUM = 1'b0, ST_HOLD = 1'b1;
  - DATA_W = 8, matching the adder width;
  - default N and ACC_W values.
- One sub-module, acc_add:
  - combinational ACC_W + 8 → ACC_W adder;
  - wraps or saturates under SUM_ACCUMULATOR_SAT_EN.
  - Used for both the acc update and the out_sum computation.
- FSM, counter and handshake logic stay in the top module.

Test Plan:
- Reset: assert rst for 3 cycles while in_valid = 1 → out_valid = 0, in_ready = 1, out_sum = 0; no sample is counted.
- Full block: N = 16, send 16 samples of value 10 with continuous valid and out_ready = 1 → exactly one beat with out_sum = 160, out_count = 16. in_ready = 0 for exactly 1 cycle, then 1.
- Back-pressure: N = 4, samples 1, 2, 3, 4, out_ready held 0 for 5 cycles → out_sum = 10 stays stable and in_ready = 0 throughout. The next block starts only after out_ready = 1.
- Flush:
  - after 3 samples of 7 → out_sum = 21, out_count = 3;
  - flush coincident with the 4th sample (value 5) → out_sum = 26, out_count = 4;
  - flush with cnt == 0 → no output.
- Overflow: ACC_W = 9, N = 4, four samples of 255 (total 1020):
  - without the macro → out_sum = 1020 mod 512 = 508;
  - with SUM_ACCUMULATOR_SAT_EN → out_sum = 511.
- Reset during HOLD with out_valid = 1 → out_valid = 0 the next cycle. The following block sums from zero (4 × 1 → out_sum = 4).
